key_issuer: RTL and testbench



---
 rtl/defuse_pkg.sv | 12 +
 rtl/lfsr18.sv | 11 +
 rtl/key_issuer.sv | 73 +++++++
 tb/tb_key_issuer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/defuse_pkg.sv
// defuse_pkg: shared constants and state encoding for the defuse game key path
package defuse_pkg;
    localparam int KEY_W = 18;
    localparam logic [KEY_W-1:0] LFSR_TAPS = 18'h20400;
    localparam logic [KEY_W-1:0] MASK_L1 = 18'h0003F;
    localparam logic [KEY_W-1:0] MASK_L2 = 18'h003FF;
    localparam logic [KEY_W-1:0] MASK_L3 = 18'h03FFF;
    localparam logic [KEY_W-1:0] MASK_L4 = 18'h3FFFF;
    localparam int LEVEL_MIN = 1;
    localparam int LEVEL_MAX = 4;
    typedef enum logic [1:0] {ST_IDLE, ST_GEN, ST_SHOW, ST_HOLD} state_e;
endpackage

// File: rtl/lfsr18.sv
// lfsr18: free-running 18-bit right-shift Galois LFSR, reloads seed on reset
module lfsr18 import defuse_pkg::*; (
    input  logic             clock,
    input  logic             reset,
    input  logic [KEY_W-1:0] seed,
    output logic [KEY_W-1:0] q
);
    logic [KEY_W-1:0] q_d;
    assign q_d = (q >> 1) ^ (q[0] ? LFSR_TAPS : '0);
    always_ff @(posedge clock) q <= reset ? seed : q_d;
endmodule

// File: rtl/key_issuer.sv
// key_issuer: draws a level-masked nonzero key from the LFSR, shows it on the
// LEDs for SHOW_TICKS ticks, then holds it for the checker until cleared.
module key_issuer #(
    parameter int               KEY_W      = 18,
    parameter logic [KEY_W-1:0] SEED       = 18'h2A5F3,
    parameter int               SHOW_TICKS = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             tick,
    input  logic             issue_req,
    input  logic [2:0]       level,
    input  logic             clear,
    output logic [KEY_W-1:0] level_key,
    output logic             key_valid,
    output logic [KEY_W-1:0] ledr,
    output logic             showing
);
    import defuse_pkg::*;

    state_e           state_q, state_d;
    logic [KEY_W-1:0] key_q, key_d, lfsr_q, mask, masked, gen_key;
    logic [2:0]       level_q, level_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             accept;

    lfsr18 u_lfsr (.clock(clock), .reset(reset), .seed(SEED), .q(lfsr_q));

    // out-of-range levels fall back to the full-width mask
    assign mask = (level_q == 3'd1) ? MASK_L1 :
                  (level_q == 3'd2) ? MASK_L2 :
                  (level_q == 3'd3) ? MASK_L3 : MASK_L4;
    assign masked  = lfsr_q & mask;
    assign gen_key = (masked == '0) ? KEY_W'(1) : masked;
    assign accept  = issue_req && (state_q == ST_IDLE || state_q == ST_HOLD);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            key_q   <= '0;
            level_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clear)
            state_d = ST_IDLE;
        else if (accept)
            state_d = ST_GEN;
        else if (state_q == ST_GEN)
            state_d = ST_SHOW;
        else if (state_q == ST_SHOW && tick && cnt_q == 4'(SHOW_TICKS - 1))
            state_d = ST_HOLD;
        key_d   = clear ? '0 : (state_q == ST_GEN) ? gen_key : key_q;
        level_d = accept ? level : level_q;
        cnt_d   = (state_q == ST_GEN) ? 4'd0 :
                  (state_q == ST_SHOW && tick) ? cnt_q + 4'd1 : cnt_q;
    end

    always_comb begin
        key_valid = (state_q == ST_SHOW) || (state_q == ST_HOLD);
        showing   = (state_q == ST_SHOW);
        level_key = key_valid ? key_q : '0;
        ledr      = showing ? key_q : '0;
    end
endmodule

// File: tb/tb_key_issuer.sv
// tb_key_issuer: directed, table-driven and randomized checks of key_issuer
// against a cycle-level behavioural model of the key issue/show/hold rules.
module tb_key_issuer;
    localparam logic [17:0] SEED = 18'h2A5F3;
    localparam int SHOW_TICKS = 3;
    localparam int P_IDLE = 0, P_GEN = 1, P_SHOW = 2, P_HOLD = 3;

    typedef struct {
        int          lvl;
        logic [17:0] allowed;
    } vec_t;

    logic clock = 0, reset = 1, tick = 0, issue_req = 0, clear = 0;
    logic [2:0] level = 0;
    logic [17:0] level_key, ledr;
    logic key_valid, showing;
    int checks = 0, failures = 0;

    logic [17:0] m_lfsr, m_key;
    int m_phase = P_IDLE, m_left = 0, m_lvl = 0;

    key_issuer #(.KEY_W(18), .SEED(SEED), .SHOW_TICKS(SHOW_TICKS)) dut (
        .clock(clock), .reset(reset), .tick(tick), .issue_req(issue_req),
        .level(level), .clear(clear), .level_key(level_key),
        .key_valid(key_valid), .ledr(ledr), .showing(showing)
    );

    always #5 clock = ~clock;

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    function automatic logic [17:0] galois(input logic [17:0] v);
        return (v >> 1) ^ (v[0] ? 18'h20400 : 18'h0);
    endfunction

    function automatic logic [17:0] mask_of(input int lvl);
        logic [63:0] one = 64'd1;
        int bits = (lvl >= 1 && lvl <= 3) ? 6 + 4 * (lvl - 1) : 18;
        return 18'((one << bits) - 64'd1);
    endfunction

    function automatic logic [17:0] key_of(input logic [17:0] v, input int lvl);
        logic [17:0] m = v & mask_of(lvl);
        return (m == 18'h0) ? 18'h1 : m;
    endfunction

    // behavioural model: phase plus ticks remaining in the display window
    always @(posedge clock) begin
        if (reset || clear) begin
            m_phase = P_IDLE;
            m_key = 18'h0;
        end else if (m_phase == P_IDLE || m_phase == P_HOLD) begin
            if (issue_req) begin
                m_phase = P_GEN;
                m_lvl = int'(level);
            end
        end else if (m_phase == P_GEN) begin
            m_key = key_of(m_lfsr, m_lvl);
            m_left = SHOW_TICKS;
            m_phase = P_SHOW;
        end else if (tick) begin
            m_left--;
            if (m_left == 0) m_phase = P_HOLD;
        end
        m_lfsr = reset ? SEED : galois(m_lfsr);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic step();
        logic v;
        @(posedge clock);
        #1;
        v = (m_phase == P_SHOW || m_phase == P_HOLD);
        check("model_valid", key_valid, v);
        check("model_key", level_key, v ? m_key : 18'h0);
        check("model_ledr", ledr, (m_phase == P_SHOW) ? m_key : 18'h0);
        check("model_showing", showing, m_phase == P_SHOW);
    endtask

    task automatic issue(input int lvl);
        level = 3'(lvl);
        issue_req = 1;
        step();
        issue_req = 0;
    endtask

    task automatic finish_show(input int expect_ticks, input int per, input string name);
        int nt = 0;
        for (int i = 0; i < 400 && showing; i++) begin
            tick = (i % per == per - 1);
            if (tick) nt++;
            step();
            tick = 0;
        end
        check(name, nt, expect_ticks);
    endtask

    initial begin
        vec_t tbl[7];
        logic [17:0] k, v;
        int found;
        tbl[0] = '{2, 18'h003FF};
        tbl[1] = '{3, 18'h03FFF};
        tbl[2] = '{4, 18'h3FFFF};
        tbl[3] = '{6, 18'h3FFFF};
        tbl[4] = '{0, 18'h3FFFF};
        tbl[5] = '{7, 18'h3FFFF};
        tbl[6] = '{5, 18'h3FFFF};

        reset = 1;
        step();
        step();
        reset = 0;
        v = SEED;
        for (int i = 0; i < 5; i++) begin
            step();
            v = galois(v);
        end
        check("lfsr_after_5", dut.u_lfsr.q, v);
        for (int i = 0; i < 5; i++) step();
        check("idle_valid", key_valid, 0);
        check("idle_ledr", ledr, 0);

        issue(1);
        k = key_of(m_lfsr, 1);
        check("l1_gen_valid", key_valid, 0);
        step();
        check("l1_valid_at_2", key_valid, 1);
        check("l1_key", level_key, k);
        check("l1_high_zero", level_key[17:6], 0);
        check("l1_ledr", ledr, k);
        finish_show(SHOW_TICKS, 20, "l1_show_ticks");
        check("l1_hold_ledr", ledr, 0);
        check("l1_hold_valid", key_valid, 1);
        check("l1_hold_key", level_key, k);

        found = 0;
        for (int i = 0; i < 5000 && !found; i++) begin
            if ((galois(m_lfsr) & 18'h3F) == 18'h0) found = 1;
            else step();
        end
        check("zero_search", found, 1);
        issue(1);
        step();
        check("zero_sub", level_key, 18'h1);
        finish_show(SHOW_TICKS, 4, "zero_show_ticks");

        foreach (tbl[i]) begin
            issue(tbl[i].lvl);
            k = key_of(m_lfsr, tbl[i].lvl);
            step();
            check("tbl_key", level_key, k);
            check("tbl_mask", level_key & ~tbl[i].allowed, 0);
            finish_show(SHOW_TICKS, 4, "tbl_show_ticks");
        end

        clear = 1;
        issue_req = 1;
        level = 3'd2;
        step();
        clear = 0;
        issue_req = 0;
        check("prio_valid", key_valid, 0);
        check("prio_key", level_key, 0);
        step();
        check("prio_stays_idle", key_valid, 0);

        issue(3);
        k = key_of(m_lfsr, 3);
        step();
        tick = 1;
        step();
        tick = 0;
        issue(1);
        step();
        check("midshow_key", level_key, k);
        check("midshow_showing", showing, 1);
        finish_show(SHOW_TICKS - 1, 4, "midshow_ticks");

        clear = 1;
        step();
        clear = 0;
        issue(2);
        step();
        tick = 1;
        step();
        tick = 0;
        check("rst_pre_showing", showing, 1);
        reset = 1;
        step();
        reset = 0;
        check("rst_valid", key_valid, 0);
        check("rst_ledr", ledr, 0);
        check("rst_key", level_key, 0);
        issue(4);
        step();
        finish_show(SHOW_TICKS, 4, "rst_restart_ticks");

        for (int i = 0; i < 3000; i++) begin
            issue_req = ($urandom % 12 == 0);
            tick = ($urandom % 6 == 0);
            clear = ($urandom % 80 == 0);
            reset = ($urandom % 600 == 0);
            level = 3'($urandom % 8);
            step();
        end
        {issue_req, tick, clear, reset} = '0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
